i2s_audio_in: RTL
=================

Name: i2s_audio_in

Overview:
- I2S/LSB-justified serial audio receiver that operates as a slave to an external bit clock and word-select signal. It is the receive-side counterpart of i2s_audio_out.
- It oversamples bclk, lrclk and sdata in the system clock domain and deserialises each left and right slot. It presents a parallel stereo sample pair with a one-cycle valid strobe.
- Use cases: loopback verification of i2s_audio_out on the board GPIO header, and capture of external I2S ADC / codec sources into lab_top.

Parameters:
- out_res, 16: output sample width in bits.
- max_slot, 32: maximum legal bits per channel slot. Longer slots flag sync loss.
- align_right, 0: 1 = LSB-justified format (PT8211 style); 0 = MSB-first, left-justified.
- offset_by_one_cycle, 1: only applies when align_right = 0. 1 = MSB arrives one bclk after the lrclk edge (Philips I2S); 0 = MSB coincides with the lrclk edge.

Ports:
- clk, input, 1: system clock. Frequency must be at least 4x the bclk frequency.
- rst_n, input, 1: asynchronous active-low reset.
- bclk, input, 1: serial bit clock, asynchronous to clk.
- lrclk, input, 1: word select, asynchronous to clk. 0 = left slot, 1 = right slot.
- sdata, input, 1: serial data, MSB first.
- sample_l, output, out_res: last complete left sample.
- sample_r, output, out_res: last complete right sample.
- valid, output, 1: one-clk pulse when sample_l and sample_r update together.
- sync_lost, output, 1: sticky error flag. Cleared only by reset.

Behaviour:
- Input synchronisation:
  - bclk, lrclk and sdata each pass through a 2-FF synchroniser.
  - A bclk rising edge is detected from the synchronised bclk plus one history FF.
  - lrclk and sdata are sampled only on detected bclk rising edges.
- Bit counting:
  - Per-slot bit counter, width $clog2(max_slot+2).
  - Resets to 0 on each lrclk change and increments on every bclk rising edge.
  - Saturates at max_slot+1.
- Shift register (out_res bits, shifts in at the LSB):
  - align_right = 1: shifts on every bit of the slot and is cleared at slot start. It therefore holds the last out_res bits. A slot shorter than out_res yields zero-filled upper bits.
  - align_right = 0: shifts only bits with index k where off ≤ k < off + out_res, with off = offset_by_one_cycle. When the slot ends, the value is left-shifted by the number of missing bits, so a short slot is zero-padded at the LSB end.
  - offset_by_one_cycle = 1: bit index 0 of each slot (the previous slot's LSB) is discarded.
- FSM states WAIT_SYNC, LEFT, RIGHT. A slot ends on the first bclk rising edge at which sampled lrclk differs from the previous sampled lrclk.
  - WAIT_SYNC: entered at reset. Ignores data. On an lrclk 1→0 edge goes to LEFT. A 0→1 edge is ignored.
  - LEFT: on slot end, latches the left word into a holding register and goes to RIGHT.
  - RIGHT: on slot end, loads the holding register into sample_l and the right word into sample_r, pulses valid, and goes to LEFT.
  - sample_l and sample_r never update separately.
- Latency:
  - valid is high exactly 1 clk, registered.
  - It asserts no more than 5 clk after the bclk pin rising edge that ends the right slot.
  - sample_l and sample_r are stable in the same cycle that valid is high and hold until the next valid.
- Sync loss:
  - Any slot whose counter reaches max_slot+1 sets sync_lost, forces the FSM to WAIT_SYNC, and suppresses valid for that frame.
  - Reception resumes at the next 1→0 lrclk edge; sync_lost stays 1.
- Idle: when bclk stops, state is held and no valid is produced.
- Reset values: sample_l = 0, sample_r = 0, valid = 0, sync_lost = 0, FSM = WAIT_SYNC, counters and shift register = 0.
- Reset mid-frame: all state is cleared immediately (asynchronous). The first valid requires a full left slot followed by a full right slot after the next 1→0 lrclk edge.
- Timing constraint: bclk high and low phases are each ≥ 2 clk periods. Behaviour outside this limit is undefined.

Test Plan:
- Philips I2S (align_right = 0, offset = 1, out_res = 16), 32-bit slots, L = 16'h8001, R = 16'h7FFE, clk = 27 MHz, bclk = 27/8 MHz → valid once per frame; sample_l = 16'h8001, sample_r = 16'h7FFE; valid ≤ 5 clk after the last right-slot bclk edge.
- LSB-justified (align_right = 1), 32-bit slots, L = 16'h1234, R = 16'hABCD, padding bits = 1 → sample_l = 16'h1234, sample_r = 16'hABCD.
- Left-justified, offset = 0, 12-bit slots, L = 12'hFFF → sample_l = 16'hFFF0 (LSB zero-padded).
- Reset asserted mid-right-slot, stream then restarted at a 0→1 lrclk edge → no valid until the first complete L+R pair after the next 1→0 edge; outputs read 0 in between.
- One 40-bit slot injected with max_slot = 32 → sync_lost = 1 and no valid for that frame; following frames decode correctly; sync_lost remains 1 until rst_n is asserted.
- Loopback with i2s_audio_out driving this block using the matching format parameters, sound ramp 0..1023 → received samples equal transmitted values in order with no dropped frames.

Source files
------------

// File: rtl/i2s_audio_in.sv
// i2s_audio_in: slave-mode serial audio receiver.
// Oversamples bclk/lrclk/sdata in the clk domain, deserialises left and right
// slots (Philips I2S, left-justified or LSB-justified) and presents a stereo
// pair with a one-cycle valid strobe. Slots longer than max_slot raise a
// sticky sync_lost flag and force a resync on the next left-slot edge.
module i2s_audio_in #(
  parameter int out_res             = 16,
  parameter int max_slot            = 32,
  parameter int align_right         = 0,
  parameter int offset_by_one_cycle = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bclk,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [out_res-1:0] sample_l,
  output logic [out_res-1:0] sample_r,
  output logic               valid,
  output logic               sync_lost
);

  localparam int CW = $clog2(max_slot + 2);
  localparam logic [CW-1:0] CNT_SAT = CW'(max_slot + 1);
  // Index of the first data bit inside a slot (only meaningful when MSB-first).
  localparam int OFF = (align_right == 0 && offset_by_one_cycle != 0) ? 1 : 0;

  typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} state_t;

  logic [1:0]         bclk_s, lr_s, sd_s;
  logic               bclk_d;
  logic               lr_prev;
  logic [CW-1:0]      cnt;
  logic [out_res-1:0] shreg;
  logic [out_res-1:0] hold_l;
  state_t             state;

  logic               rise, lr_chg, in_win;
  logic [CW-1:0]      bit_idx, cnt_next;
  logic [out_res-1:0] shreg_base, shreg_next, word;
  int                 n_bits;

  // Two-stage synchronisers plus one history stage for bclk edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_s <= '0;
      lr_s   <= '0;
      sd_s   <= '0;
      bclk_d <= 1'b0;
    end else begin
      bclk_s <= {bclk_s[0], bclk};
      lr_s   <= {lr_s[0], lrclk};
      sd_s   <= {sd_s[0], sdata};
      bclk_d <= bclk_s[1];
    end
  end

  // Per-bit datapath: slot bit index, saturating counter, shifter and the
  // justified word of the slot that is ending.
  always_comb begin
    rise       = bclk_s[1] & ~bclk_d;
    lr_chg     = lr_s[1] ^ lr_prev;
    bit_idx    = lr_chg ? '0 : cnt;
    cnt_next   = (bit_idx == CNT_SAT) ? bit_idx : bit_idx + 1'b1;
    in_win     = (align_right != 0) ||
                 ((int'(bit_idx) >= OFF) && (int'(bit_idx) < OFF + out_res));
    shreg_base = lr_chg ? '0 : shreg;
    shreg_next = in_win ? {shreg_base[out_res-2:0], sd_s[1]} : shreg_base;
    n_bits     = 0;
    if (int'(cnt) > OFF) n_bits = int'(cnt) - OFF;
    if (n_bits > out_res) n_bits = out_res;
    // MSB-first words that came up short are pushed up so the pad is at the LSB end.
    if (align_right != 0) word = shreg;
    else                  word = shreg << (out_res - n_bits);
  end

  // Slot-framing FSM with registered outputs and sticky sync-loss detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_SYNC;
      lr_prev   <= 1'b0;
      cnt       <= '0;
      shreg     <= '0;
      hold_l    <= '0;
      sample_l  <= '0;
      sample_r  <= '0;
      valid     <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (rise) begin
        lr_prev <= lr_s[1];
        cnt     <= cnt_next;
        shreg   <= shreg_next;
        case (state)
          WAIT_SYNC: begin
            if (lr_chg && !lr_s[1]) state <= LEFT;
          end
          LEFT: begin
            if (lr_chg) begin
              hold_l <= word;
              state  <= RIGHT;
            end else if (cnt_next == CNT_SAT) begin
              sync_lost <= 1'b1;
              state     <= WAIT_SYNC;
            end
          end
          RIGHT: begin
            if (lr_chg) begin
              sample_l <= hold_l;
              sample_r <= word;
              valid    <= 1'b1;
              state    <= LEFT;
            end else if (cnt_next == CNT_SAT) begin
              sync_lost <= 1'b1;
              state     <= WAIT_SYNC;
            end
          end
          default: state <= WAIT_SYNC;
        endcase
      end
    end
  end

endmodule
